// File: rtl/package_param.sv
// Shared types and constants for the instruction encoder: formats, FSM states,
// base opcodes, immediate range limits and a saturating counter helper.
package package_param;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_OP_IMM = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLTIU   = 3'd3;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;

    localparam int signed IMM12_MIN  = -2048;
    localparam int signed IMM12_MAX  = 2047;
    localparam int signed IMM12U_MAX = 4095;
    localparam int signed SHAMT_MAX  = 31;
    localparam int signed IMMB_MIN   = -4096;
    localparam int signed IMMB_MAX   = 4094;
    localparam int signed IMMJ_MIN   = -1048576;
    localparam int signed IMMJ_MAX   = 1048574;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } req_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: turns decoded instruction fields into a 32-bit word
// and flags whether the immediate is encodable for the selected format.
module inst_pack
    import package_param::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_ok
);

    logic signed [31:0] simm;
    fmt_e               fmt_sel;

    assign simm    = $signed(imm);
    assign fmt_sel = fmt_e'(fmt);

    always_comb begin
        word     = '0;
        range_ok = 1'b0;
        case (fmt_sel)
            FMT_R: begin
                word     = {funct7, rs2, rs1, funct3, rd, opcode};
                range_ok = 1'b1;
            end
            FMT_I: begin
                if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) begin
                    word     = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    range_ok = (simm >= 0) && (simm <= SHAMT_MAX);
                end else begin
                    word     = {imm[11:0], rs1, funct3, rd, opcode};
                    range_ok = (funct3 == F3_SLTIU) ?
                               ((simm >= 0) && (simm <= IMM12U_MAX)) :
                               ((simm >= IMM12_MIN) && (simm <= IMM12_MAX));
                end
            end
            FMT_S: begin
                word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_ok = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
            end
            FMT_B: begin
                word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_ok = (simm >= IMMB_MIN) && (simm <= IMMB_MAX) && !imm[0];
            end
            FMT_U: begin
                word     = {imm[31:12], rd, opcode};
                range_ok = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_ok = (simm >= IMMJ_MIN) && (simm <= IMMJ_MAX) && !imm[0];
            end
            default: begin
                word     = '0;
                range_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts field-level requests in a load session, packs them
// through a two-stage pipeline and writes the words to sequential memory addresses.
module inst_encoder
    import package_param::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_last_i,
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        err_sticky_o,
    output logic [15:0] inst_cnt_o,
    output logic [15:0] err_cnt_o
);

    state_e      state;
    req_t        s1_req;
    logic        s1_valid;
    logic        s2_valid;
    logic [31:0] s2_word;

    logic [31:0] pack_word;
    logic        pack_ok;

    logic        accept;
    logic        s2_free;
    logic        s1_adv;
    logic        wr_done;
    logic        s1_nxt;
    logic        s2_nxt;

    inst_pack u_pack (
        .fmt      (s1_req.fmt),
        .opcode   (s1_req.opcode),
        .rd       (s1_req.rd),
        .rs1      (s1_req.rs1),
        .rs2      (s1_req.rs2),
        .funct3   (s1_req.funct3),
        .funct7   (s1_req.funct7),
        .imm      (s1_req.imm),
        .word     (pack_word),
        .range_ok (pack_ok)
    );

    // Stage handshake: S1 moves on whenever S2 is empty or its write completes this cycle.
    always_comb begin
        wr_done     = s2_valid & mem_ready_i;
        s2_free     = !s2_valid | mem_ready_i;
        s1_adv      = s1_valid & s2_free;
        req_ready_o = (state == ST_LOAD) & (!s1_valid | s1_adv);
        accept      = req_valid_i & req_ready_o;
        s1_nxt      = accept | (s1_valid & !s1_adv);
        s2_nxt      = (s1_adv & pack_ok) | (s2_valid & !mem_ready_i);
    end

    assign mem_we_o    = s2_valid;
    assign mem_wdata_o = s2_word;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            s1_req       <= '0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s2_word      <= '0;
            mem_addr_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            err_sticky_o <= 1'b0;
            inst_cnt_o   <= '0;
            err_cnt_o    <= '0;
        end else begin
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            s1_valid <= s1_nxt;
            s2_valid <= s2_nxt;

            if (accept) begin
                s1_req <= '{fmt: fmt_i, opcode: opcode_i, rd: rd_i, rs1: rs1_i,
                            rs2: rs2_i, funct3: funct3_i, funct7: funct7_i, imm: imm_i};
            end

            if (s1_adv && pack_ok) begin
                s2_word <= pack_word;
            end

            // Out-of-range words vanish here instead of reaching S2.
            if (s1_adv && !pack_ok) begin
                err_o        <= 1'b1;
                err_sticky_o <= 1'b1;
                err_cnt_o    <= sat_inc(err_cnt_o);
            end

            if (wr_done) begin
                mem_addr_o <= mem_addr_o + 32'd4;
                inst_cnt_o <= sat_inc(inst_cnt_o);
            end

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state        <= ST_LOAD;
                        busy_o       <= 1'b1;
                        mem_addr_o   <= base_addr_i;
                        inst_cnt_o   <= '0;
                        err_cnt_o    <= '0;
                        err_sticky_o <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept && req_last_i) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_nxt && !s2_nxt) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have ports clk_i in 1 (system clock) and rst_i in 1 (reset); one clock; reset is synchronous and active-high.
REQ-002 SHALL have start_i in 1 (open load session) and base_addr_i in 32 (first write address, word aligned).
REQ-003 SHALL have req_valid_i in 1, req_ready_o out 1, req_last_i in 1 (final request of session).
REQ-004 SHALL have fmt_i in 3 (fmt_e: R,I,S,B,U,J) and opcode_i in 7.
REQ-005 SHALL have rd_i/rs1_i/rs2_i in 5 each, funct3_i in 3, funct7_i in 7, imm_i in 32 (signed value, byte offset for B/J).
REQ-006 SHALL have mem_we_o out 1, mem_addr_o out 32, mem_wdata_o out 32, mem_ready_i in 1 (memory accepts write).
REQ-007 SHALL have busy_o out 1, done_o out 1 (one-cycle pulse), err_o out 1 (one-cycle pulse), err_sticky_o out 1, inst_cnt_o out 16, err_cnt_o out 16.

Function
REQ-008 SHALL implement FSM IDLE -> LOAD on start_i; LOAD -> DRAIN on accepted request with req_last_i=1; DRAIN -> IDLE when both pipeline stages empty, with done_o pulsed that cycle.
REQ-009 SHALL ignore start_i outside IDLE; on start_i in IDLE load address counter with base_addr_i and clear inst_cnt_o, err_cnt_o, err_sticky_o.
REQ-010 SHALL assert req_ready_o only in LOAD and when stage-1 is empty or advancing; a transfer occurs on req_valid_i & req_ready_o.
REQ-011 SHALL use two stages: S1 registers the raw request; S2 holds the packed word; S1 advances when S2 is empty or S2 write completes.
REQ-012 SHALL present mem_we_o=1 from S2 exactly two cycles after acceptance when not back-pressured; hold mem_addr_o/mem_wdata_o stable until mem_ready_i=1.
REQ-013 SHALL sustain one instruction per cycle while mem_ready_i=1.
REQ-014 SHALL pack: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-015 SHALL for I with funct3 1 or 5 place funct7_i in [31:25] and require imm_i in 0..31.
REQ-016 SHALL for I with funct3 3 require imm_i in 0..4095 (zero-extended form); other I and all S require -2048..2047.
REQ-017 SHALL require B in -4096..4094 and even; J in -1048576..1048574 and even; U with imm_i[11:0]=0.
REQ-018 SHALL on range violation drop the word (no write, no address increment), pulse err_o when leaving S1, increment err_cnt_o, set err_sticky_o.
REQ-019 SHALL increment mem_addr counter by 4 and inst_cnt_o by 1 per completed write; address wraps modulo 2^32; counters saturate at 16'hFFFF.
REQ-020 SHALL keep busy_o=1 in LOAD and DRAIN.
REQ-021 SHALL treat an invalid fmt_i code as a range violation.

Reset
REQ-022 SHALL on rst_i=1 at a clock edge enter IDLE, clear both stage valids, and drive req_ready_o, mem_we_o, busy_o, done_o, err_o, err_sticky_o=0, counters=0, mem_addr_o=0, mem_wdata_o=0.
REQ-023 SHALL abandon any in-flight word when reset occurs mid-session; the word SHALL NOT be written.

Structure
REQ-024 SHALL place fmt_e, state enum, opcode constants and range limit constants in package_param.
REQ-025 SHALL contain one combinational sub-module inst_pack (fields+fmt -> word, range_ok); FSM, stages, counters live in inst_encoder.

Verification
REQ-026 start_i, base 0x100, I addi x1,x0,-1 (op 0x13) -> write 0xFFF00093 @0x100, two cycles after acceptance.
REQ-027 B beq x1,x2,-4 (op 0x63) then J jal x1,+2048 (op 0x6F) -> 0xFE208EE3 @base, 0x001000EF @base+4.
REQ-028 I funct3 0 imm 2048; then B imm 3 -> no writes, err_o pulses twice, err_cnt_o=2, err_sticky_o=1, address unchanged.
REQ-029 mem_ready_i low 5 cycles during back-to-back stream of 4 -> req_ready_o drops, outputs held stable, all 4 written in order, no loss or duplicates.
REQ-030 last request with req_last_i=1 -> DRAIN, done_o single pulse after final write, busy_o falls, inst_cnt_o matches writes.
REQ-031 rst_i asserted with S1 and S2 full -> next cycle IDLE, mem_we_o=0, counters 0, no write.
